// File: rtl/smi_wbbus.sv
// SMI byte-stream to pipelined Wishbone master: set-address / write / read commands, byte responses.
// Build option: define SMI_WBBUS_AUTOINC_EN to advance the address after every acked access.
module smi_wbbus #(
    parameter int AW = 30
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          S_RX_VALID,
    output logic          S_RX_READY,
    input  logic [7:0]    S_RX_DATA,
    output logic          M_TX_VALID,
    input  logic          M_TX_READY,
    output logic [7:0]    M_TX_DATA,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [31:0]   o_wb_data,
    output logic [3:0]    o_wb_sel,
    input  logic          i_wb_stall,
    input  logic          i_wb_ack,
    input  logic          i_wb_err,
    input  logic [31:0]   i_wb_data
);

    typedef enum logic [2:0] {S_IDLE, S_ARG, S_BUS, S_WAIT, S_RESP} state_t;

    state_t         state_q;
    logic           is_write_q;
    logic [1:0]     arg_cnt_q;
    logic [31:0]    arg_q;
    logic [AW-1:0]  addr_q;
    logic [39:0]    resp_q;
    logic [2:0]     resp_cnt_q;
    logic           cyc_q;
    logic           stb_q;
    logic           we_q;
    logic           tx_valid_q;
    logic [31:0]    arg_d;

    assign arg_d = {arg_q[23:0], S_RX_DATA};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            arg_cnt_q  <= 2'd0;
            arg_q      <= 32'h0;
            addr_q     <= '0;
            resp_q     <= 40'h0;
            resp_cnt_q <= 3'd0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            tx_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (S_RX_VALID) begin
                        arg_cnt_q <= 2'd0;
                        case (S_RX_DATA)
                            8'h01: begin
                                is_write_q <= 1'b0;
                                state_q    <= S_ARG;
                            end
                            8'h02: begin
                                is_write_q <= 1'b1;
                                state_q    <= S_ARG;
                            end
                            8'h03: begin
                                we_q    <= 1'b0;
                                cyc_q   <= 1'b1;
                                stb_q   <= 1'b1;
                                state_q <= S_BUS;
                            end
                            default: begin
                                resp_q     <= {8'hEF, 32'h0};
                                resp_cnt_q <= 3'd1;
                                tx_valid_q <= 1'b1;
                                state_q    <= S_RESP;
                            end
                        endcase
                    end
                end
                S_ARG: begin
                    if (S_RX_VALID) begin
                        arg_q     <= arg_d;
                        arg_cnt_q <= arg_cnt_q + 1'b1;
                        if (arg_cnt_q == 2'd3) begin
                            if (is_write_q) begin
                                we_q    <= 1'b1;
                                cyc_q   <= 1'b1;
                                stb_q   <= 1'b1;
                                state_q <= S_BUS;
                            end else begin
                                addr_q  <= arg_d[AW-1:0];
                                state_q <= S_IDLE;
                            end
                        end
                    end
                end
                S_BUS, S_WAIT: begin
                    if (!i_wb_stall) begin
                        stb_q <= 1'b0;
                        if (state_q == S_BUS) state_q <= S_WAIT;
                    end
                    // A response in the request cycle itself skips WAIT entirely.
                    if (i_wb_ack || i_wb_err) begin
                        cyc_q      <= 1'b0;
                        stb_q      <= 1'b0;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_RESP;
                        if (i_wb_err) begin
                            resp_q     <= {8'hE0, 32'h0};
                            resp_cnt_q <= 3'd1;
                        end else if (we_q) begin
                            resp_q     <= {8'h82, 32'h0};
                            resp_cnt_q <= 3'd1;
                        end else begin
                            resp_q     <= {8'h83, i_wb_data};
                            resp_cnt_q <= 3'd5;
                        end
`ifdef SMI_WBBUS_AUTOINC_EN
                        if (!i_wb_err) addr_q <= addr_q + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    if (M_TX_READY) begin
                        if (resp_cnt_q == 3'd1) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            resp_q     <= {resp_q[31:0], 8'h00};
                            resp_cnt_q <= resp_cnt_q - 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign S_RX_READY = (state_q == S_IDLE) || (state_q == S_ARG);
    assign M_TX_VALID = tx_valid_q;
    assign M_TX_DATA  = resp_q[39:32];
    assign o_wb_cyc   = cyc_q;
    assign o_wb_stb   = stb_q;
    assign o_wb_we    = we_q;
    assign o_wb_addr  = addr_q;
    assign o_wb_data  = arg_q;
    assign o_wb_sel   = 4'hf;

endmodule

// File: tb/tb_smi_wbbus.sv
// Scoreboard bench for smi_wbbus: command-level reference model, randomized slave timing and errors.
`timescale 1ns/1ps
module tb_smi_wbbus;
    localparam int AW = 30;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          S_RX_VALID = 1'b0;
    logic          S_RX_READY;
    logic [7:0]    S_RX_DATA = 8'h0;
    logic          M_TX_VALID;
    logic          M_TX_READY = 1'b0;
    logic [7:0]    M_TX_DATA;
    logic          o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [31:0]   o_wb_data;
    logic [3:0]    o_wb_sel;
    logic          i_wb_stall = 1'b0, i_wb_ack = 1'b0, i_wb_err = 1'b0;
    logic [31:0]   i_wb_data = 32'h0;

    smi_wbbus #(.AW(AW)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .S_RX_VALID(S_RX_VALID), .S_RX_READY(S_RX_READY), .S_RX_DATA(S_RX_DATA),
        .M_TX_VALID(M_TX_VALID), .M_TX_READY(M_TX_READY), .M_TX_DATA(M_TX_DATA),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .i_wb_data(i_wb_data)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {logic [AW-1:0] addr; logic we; logic [31:0] data;} bus_t;
    typedef struct packed {logic err; logic [3:0] lat;} plan_t;

    int checks = 0;
    int errors = 0;
    logic [7:0]  exp_tx[$];
    bus_t        exp_bus[$];
    plan_t       plan_q[$];
    logic [31:0] model_mem [logic [AW-1:0]];
    logic [31:0] slave_mem [logic [AW-1:0]];
    logic [AW-1:0] model_addr = '0;
    bit force_low = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        S_RX_VALID = 1'b1;
        S_RX_DATA  = b;
        do begin
            @(negedge i_clk);
            n++;
        end while (!S_RX_READY && n < 500);
        if (!S_RX_READY) chk("rx_accept_timeout", 64'd0, 64'd1);
        @(posedge i_clk); #1;
        S_RX_VALID = 1'b0;
        S_RX_DATA  = 8'($urandom);
        repeat ($urandom_range(0, 1)) begin
            @(posedge i_clk); #1;
        end
    endtask

    // Reference behaviour at command level: predicts the bus request and response bytes.
    task automatic do_cmd(input logic [7:0] op, input logic [31:0] val, input bit err,
                          input int lat, input bit resp_ok);
        bus_t e;
        plan_t p;
        logic [31:0] rd;
        $display("cmd %02h arg %08h err %0d addr %08h", op, val, err, model_addr);
        p.err = err;
        p.lat = 4'(lat);
        case (op)
            8'h01: model_addr = val[AW-1:0];
            8'h02: begin
                e.addr = model_addr; e.we = 1'b1; e.data = val;
                exp_bus.push_back(e);
                plan_q.push_back(p);
                if (resp_ok) exp_tx.push_back(err ? 8'hE0 : 8'h82);
                if (!err) begin
                    model_mem[model_addr] = val;
`ifdef SMI_WBBUS_AUTOINC_EN
                    model_addr = model_addr + 1'b1;
`endif
                end
            end
            8'h03: begin
                rd = model_mem.exists(model_addr) ? model_mem[model_addr] : 32'h0;
                e.addr = model_addr; e.we = 1'b0; e.data = 32'h0;
                exp_bus.push_back(e);
                plan_q.push_back(p);
                if (resp_ok) begin
                    if (err) exp_tx.push_back(8'hE0);
                    else begin
                        exp_tx.push_back(8'h83);
                        for (int i = 3; i >= 0; i--) exp_tx.push_back(rd[8*i +: 8]);
                    end
                end
`ifdef SMI_WBBUS_AUTOINC_EN
                if (!err) model_addr = model_addr + 1'b1;
`endif
            end
            default: if (resp_ok) exp_tx.push_back(8'hEF);
        endcase
        send_byte(op);
        if (op == 8'h01 || op == 8'h02)
            for (int i = 3; i >= 0; i--) send_byte(val[8*i +: 8]);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_tx.size() != 0 || exp_bus.size() != 0) && n < 3000) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("drain_timeout", 64'(exp_tx.size() + exp_bus.size()), 64'd0);
        repeat (2) begin
            @(posedge i_clk); #1;
        end
    endtask

    // Response ready: random, or held low for the back-pressure check.
    initial forever begin
        @(posedge i_clk); #2;
        M_TX_READY = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Wishbone slave with planned latency/error and random stalls.
    initial begin
        bit acc, pending, cur_err, we_c;
        int cnt;
        logic [AW-1:0] addr_c;
        logic [31:0] wd_c, rdata;
        plan_t p;
        pending = 0; cnt = 0; cur_err = 0; rdata = 0;
        forever begin
            @(negedge i_clk);
            acc    = !i_reset && o_wb_cyc && o_wb_stb && !i_wb_stall;
            addr_c = o_wb_addr;
            we_c   = o_wb_we;
            wd_c   = o_wb_data;
            @(posedge i_clk); #1;
            i_wb_ack  = 1'b0;
            i_wb_err  = 1'b0;
            i_wb_data = $urandom;
            if (i_reset) begin
                pending = 0;
                i_wb_stall = 1'b0;
                continue;
            end
            if (acc) begin
                if (plan_q.size() == 0) begin
                    p.err = 1'b0; p.lat = 4'd1;
                end else p = plan_q.pop_front();
                pending = 1;
                cnt     = int'(p.lat) - 1;
                cur_err = p.err;
                if (we_c) begin
                    if (!p.err) slave_mem[addr_c] = wd_c;
                    rdata = 32'h0;
                end else rdata = slave_mem.exists(addr_c) ? slave_mem[addr_c] : 32'h0;
            end
            if (pending) begin
                if (cnt <= 0) begin
                    if (cur_err) i_wb_err = 1'b1; else i_wb_ack = 1'b1;
                    i_wb_data = rdata;
                    pending = 0;
                end else cnt--;
            end else if (!o_wb_cyc) begin
                i_wb_ack = ($urandom_range(0, 9) == 0);
            end
            i_wb_stall = o_wb_stb && !pending && ($urandom_range(0, 2) == 0);
        end
    end

    // Bus request monitor.
    initial forever begin
        bus_t e;
        @(negedge i_clk);
        if (!i_reset && o_wb_cyc && o_wb_stb && !i_wb_stall) begin
            if (exp_bus.size() == 0) chk("bus_unexpected_request", 64'd1, 64'd0);
            else begin
                e = exp_bus.pop_front();
                $display("bus %s addr %08h data %08h", o_wb_we ? "wr" : "rd", o_wb_addr, o_wb_data);
                chk("bus_addr", 64'(o_wb_addr), 64'(e.addr));
                chk("bus_we", 64'(o_wb_we), 64'(e.we));
                chk("bus_sel", 64'(o_wb_sel), 64'hf);
                if (e.we) chk("bus_wdata", 64'(o_wb_data), 64'(e.data));
            end
        end
    end

    // Response byte monitor with stability check while stalled.
    initial begin
        logic [7:0] hold;
        bit held;
        held = 0; hold = 0;
        forever begin
            @(negedge i_clk);
            if (i_reset) held = 0;
            else begin
                if (held) begin
                    chk("tx_valid_hold", 64'(M_TX_VALID), 64'd1);
                    chk("tx_data_hold", 64'(M_TX_DATA), 64'(hold));
                end
                held = 0;
                if (M_TX_VALID) begin
                    if (M_TX_READY) begin
                        if (exp_tx.size() == 0) chk("tx_unexpected_byte", 64'(M_TX_DATA), 64'h100);
                        else chk("tx_byte", 64'(M_TX_DATA), 64'(exp_tx.pop_front()));
                    end else begin
                        held = 1;
                        hold = M_TX_DATA;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] b;
        logic [31:0] v;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_cyc", 64'(o_wb_cyc), 64'd0);
        chk("rst_stb", 64'(o_wb_stb), 64'd0);
        chk("rst_we", 64'(o_wb_we), 64'd0);
        chk("rst_txv", 64'(M_TX_VALID), 64'd0);
        chk("rst_addr", 64'(o_wb_addr), 64'd0);
        chk("rst_sel", 64'(o_wb_sel), 64'hf);
        chk("rst_data", 64'(o_wb_data), 64'd0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("idle_rx_ready", 64'(S_RX_READY), 64'd1);
        @(posedge i_clk); #1;

        do_cmd(8'h01, 32'h0000_0010, 0, 1, 1);
        do_cmd(8'h02, 32'hDEAD_BEEF, 0, 2, 1);
        do_cmd(8'h01, 32'h0000_0010, 0, 1, 1);
        do_cmd(8'h03, 32'h0, 0, 1, 1);
        do_cmd(8'h01, 32'h0000_0010, 0, 1, 1);
        do_cmd(8'h02, 32'h1234_5678, 0, 1, 1);
        do_cmd(8'h01, 32'h0000_0010, 0, 1, 1);
        do_cmd(8'h03, 32'h0, 0, 3, 1);
        do_cmd(8'h01, 32'h3FFF_FFFF, 0, 1, 1);
        do_cmd(8'h03, 32'h0, 0, 1, 1);
        do_cmd(8'h03, 32'h0, 0, 2, 1);
        do_cmd(8'h01, 32'hC000_0005, 0, 1, 1);
        do_cmd(8'h02, 32'h0000_0001, 1, 2, 1);
        do_cmd(8'h03, 32'h0, 0, 1, 1);
        drain();

        force_low = 1'b1;
        @(posedge i_clk); #1;
        do_cmd(8'h55, 32'h0, 0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            chk("bp_txv", 64'(M_TX_VALID), 64'd1);
            chk("bp_txdata", 64'(M_TX_DATA), 64'hEF);
            chk("bp_rx_ready", 64'(S_RX_READY), 64'd0);
            chk("bp_cyc", 64'(o_wb_cyc), 64'd0);
        end
        @(posedge i_clk); #1;
        force_low = 1'b0;
        drain();

        do_cmd(8'h01, 32'h0000_0020, 0, 1, 1);
        do_cmd(8'h03, 32'h0, 0, 15, 0);
        n = 0;
        while (!(o_wb_cyc && !o_wb_stb) && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        chk("wait_reached", 64'(o_wb_cyc && !o_wb_stb), 64'd1);
        #2 i_reset = 1'b1;
        #1;
        chk("arst_cyc", 64'(o_wb_cyc), 64'd0);
        chk("arst_stb", 64'(o_wb_stb), 64'd0);
        chk("arst_txv", 64'(M_TX_VALID), 64'd0);
        chk("arst_addr", 64'(o_wb_addr), 64'd0);
        model_addr = '0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        @(posedge i_clk); #1;
        do_cmd(8'h03, 32'h0, 0, 1, 1);
        drain();

        for (int t = 0; t < 120; t++) begin
            n = $urandom_range(0, 9);
            v = $urandom;
            if (n < 3) begin
                if ($urandom_range(0, 1) == 0) v[29:0] = 30'($urandom_range(0, 7));
                else v[29:0] = 30'h3FFF_FFFF - 30'($urandom_range(0, 3));
                do_cmd(8'h01, v, 0, 1, 1);
            end else if (n < 6) begin
                do_cmd(8'h02, v, ($urandom_range(0, 6) == 0), $urandom_range(1, 3), 1);
            end else if (n < 9) begin
                do_cmd(8'h03, v, ($urandom_range(0, 6) == 0), $urandom_range(1, 3), 1);
            end else begin
                do begin
                    b = 8'($urandom);
                end while (b == 8'h01 || b == 8'h02 || b == 8'h03);
                do_cmd(b, v, 0, 1, 1);
            end
        end
        drain();
        chk("plan_left", 64'(plan_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
